// File: rtl/mem_access_pkg.sv
// Shared encodings for the memory-stage access controller: EX/MEM load/store codes,
// controller states and byte-enable patterns.
package mem_access_pkg;

    localparam logic [2:0] MR_NONE = 3'b000;
    localparam logic [2:0] MR_LB   = 3'b001;
    localparam logic [2:0] MR_LH   = 3'b010;
    localparam logic [2:0] MR_LW   = 3'b011;
    localparam logic [2:0] MR_LBU  = 3'b100;
    localparam logic [2:0] MR_LHU  = 3'b101;

    localparam logic [1:0] MW_NONE = 2'b00;
    localparam logic [1:0] MW_SB   = 2'b01;
    localparam logic [1:0] MW_SH   = 2'b10;
    localparam logic [1:0] MW_SW   = 2'b11;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_load_op(input logic [2:0] op);
        return op inside {MR_LB, MR_LH, MR_LW, MR_LBU, MR_LHU};
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Store-lane replication/byte enables and load byte/half extraction with extension.
// Purely combinational, zero latency, no backpressure.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [1:0]  st_op,
    input  logic [31:0] st_data,
    input  logic [1:0]  st_off,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    input  logic [2:0]  ld_op,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_wdata = '0;
        st_be    = BE_NONE;
        case (st_op)
            MW_SB: begin
                st_wdata = {4{st_data[7:0]}};
                st_be    = BE_BYTE << st_off;
            end
            MW_SH: begin
                st_wdata = {2{st_data[15:0]}};
                st_be    = BE_HALF << {st_off[1], 1'b0};
            end
            MW_SW: begin
                st_wdata = st_data;
                st_be    = BE_WORD;
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte = ld_word[{ld_off, 3'b000} +: 8];
        ld_half = ld_word[{ld_off[1], 4'b0000} +: 16];
        ld_data = '0;
        case (ld_op)
            MR_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            MR_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            MR_LW:   ld_data = ld_word;
            MR_LBU:  ld_data = {24'h0, ld_byte};
            MR_LHU:  ld_data = {16'h0, ld_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage controller: turns EX/MEM load/store into a req/ack data-memory transaction.
// Latency 2 cycles + memory wait; stalls the pipeline from access detect until ack or timeout.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  in_mem_read,
    input  logic [1:0]  in_mem_write,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_rd2,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        misalign,
    output logic        bus_err
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state, state_nxt;
    logic [7:0]  wait_cnt;
    logic [2:0]  op_q;
    logic [1:0]  off_q;

    logic        is_store, is_load, access, misaligned;
    logic        start, reject, acked, timed_out;
    logic [31:0] st_wdata, ld_data;
    logic [3:0]  st_be;

    // A store takes precedence; the read encoding is ignored when both are set.
    assign is_store = (in_mem_write != MW_NONE);
    assign is_load  = !is_store && is_load_op(in_mem_read);
    assign access   = is_store || is_load;

    always_comb begin
        misaligned = 1'b0;
        if (is_store) begin
            case (in_mem_write)
                MW_SH:   misaligned = in_alu_result[0];
                MW_SW:   misaligned = |in_alu_result[1:0];
                default: misaligned = 1'b0;
            endcase
        end else begin
            case (in_mem_read)
                MR_LH, MR_LHU: misaligned = in_alu_result[0];
                MR_LW:         misaligned = |in_alu_result[1:0];
                default:       misaligned = 1'b0;
            endcase
        end
    end

    mem_lane_align u_lane (
        .st_op    (in_mem_write),
        .st_data  (in_rd2),
        .st_off   (in_alu_result[1:0]),
        .st_wdata (st_wdata),
        .st_be    (st_be),
        .ld_op    (op_q),
        .ld_off   (off_q),
        .ld_word  (dmem_rdata),
        .ld_data  (ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        start     = 1'b0;
        reject    = 1'b0;
        acked     = 1'b0;
        timed_out = 1'b0;
        case (state)
            ST_IDLE: begin
                if (access) begin
                    if (misaligned) begin
                        reject = 1'b1;
                    end else begin
                        start     = 1'b1;
                        stall     = 1'b1;
                        state_nxt = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                stall = 1'b1;
                // An ack arriving on the final allowed cycle still completes normally.
                if (dmem_ack) begin
                    acked     = 1'b1;
                    state_nxt = ST_DONE;
                end else if (wait_cnt == TO_LAST) begin
                    timed_out = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            // DONE always returns to IDLE so the still-visible instruction is not reissued.
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt   <= '0;
            op_q       <= MR_NONE;
            off_q      <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_be    <= BE_NONE;
            load_data  <= '0;
            load_valid <= 1'b0;
            misalign   <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            misalign   <= reject;
            load_valid <= acked && !dmem_we;
            bus_err    <= timed_out;
            wait_cnt   <= (state == ST_REQ) ? wait_cnt + 8'd1 : 8'd0;
            if (start) begin
                dmem_req   <= 1'b1;
                dmem_we    <= is_store;
                dmem_addr  <= {in_alu_result[31:2], 2'b00};
                dmem_wdata <= st_wdata;
                dmem_be    <= st_be;
                op_q       <= is_store ? MR_NONE : in_mem_read;
                off_q      <= in_alu_result[1:0];
            end
            if (acked || timed_out) dmem_req <= 1'b0;
            if (acked && !dmem_we)  load_data <= ld_data;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases then random load/store traffic checked
// against an arithmetic reference model of addressing, lanes and timing.
module tb_mem_access_unit;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  in_mem_read;
    logic [1:0]  in_mem_write;
    logic [31:0] in_alu_result;
    logic [31:0] in_rd2;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid, misalign, bus_err;

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [31:0] last_load = 32'h0;

    mem_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_mem_read   (in_mem_read),
        .in_mem_write  (in_mem_write),
        .in_alu_result (in_alu_result),
        .in_rd2        (in_rd2),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_be       (dmem_be),
        .dmem_ack      (dmem_ack),
        .dmem_rdata    (dmem_rdata),
        .stall         (stall),
        .load_data     (load_data),
        .load_valid    (load_valid),
        .misalign      (misalign),
        .bus_err       (bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_mem_read   = 3'b000;
        in_mem_write  = 2'b00;
        in_alu_result = 32'h0;
        in_rd2        = 32'h0;
    endtask

    // Reference load extraction: shift the addressed lane down, mask, extend.
    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [1:0] off,
                                             input logic [31:0] word);
        logic [31:0] b, h;
        b = (word >> (off * 8)) & 32'hFF;
        h = (word >> (off[1] * 16)) & 32'hFFFF;
        case (op)
            3'd1:    return b[7]  ? (b | 32'hFFFF_FF00) : b;
            3'd2:    return h[15] ? (h | 32'hFFFF_0000) : h;
            3'd3:    return word;
            3'd4:    return b;
            3'd5:    return h;
            default: return 32'h0;
        endcase
    endfunction

    // One EX/MEM instruction from first appearance until the pipeline moves on.
    // wait_n = number of REQ cycles before ack; wait_n >= TMO means no ack at all.
    task automatic run_op(input logic [2:0] rd, input logic [1:0] wr, input logic [31:0] addr,
                          input logic [31:0] d, input logic [31:0] rword, input int wait_n);
        bit          st, ld, acc, mis, got;
        int          size;
        logic [1:0]  off;
        logic [31:0] exp_wd, exp_ld;
        logic [3:0]  exp_be;
        st   = (wr != 2'b00);
        ld   = !st && rd >= 3'd1 && rd <= 3'd5;
        acc  = st || ld;
        size = st ? ((wr == 2'd3) ? 4 : int'(wr)) : ((rd == 3'd3) ? 4 : (rd == 3'd2 || rd == 3'd5) ? 2 : 1);
        off  = addr[1:0];
        mis  = acc && ((addr & 32'(size - 1)) != 32'h0);
        exp_be = (size == 1) ? (4'b0001 << off) : (size == 2) ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        exp_wd = (size == 1) ? (d & 32'hFF) * 32'h0101_0101 :
                 (size == 2) ? (d & 32'hFFFF) * 32'h0001_0001 : d;

        in_mem_read = rd; in_mem_write = wr; in_alu_result = addr; in_rd2 = d;
        dmem_ack = 1'b0;
        #1;
        check("stall_first_cycle", stall, acc && !mis);
        tick();
        if (!acc || mis) begin
            clear_inputs();
            #1;
            check("misalign_pulse", misalign, mis);
            check("no_req_when_rejected", dmem_req, 0);
            check("stall_when_rejected", stall, 0);
            tick();
            check("misalign_single", misalign, 0);
            return;
        end
        got = 0;
        for (int k = 0; k < TMO && !got; k++) begin
            check("req_held", dmem_req, 1);
            check("stall_in_req", stall, 1);
            check("dmem_addr", dmem_addr, {addr[31:2], 2'b00});
            check("dmem_we", dmem_we, st);
            if (st) begin
                check("dmem_wdata", dmem_wdata, exp_wd);
                check("dmem_be", dmem_be, exp_be);
            end
            check("no_early_load_valid", load_valid, 0);
            if (k == wait_n) begin
                dmem_ack = 1'b1; dmem_rdata = rword; got = 1;
            end else begin
                dmem_ack = 1'b0; dmem_rdata = $urandom;
            end
            tick();
        end
        // DONE cycle; a stray ack here must be ignored.
        dmem_ack = 1'($urandom_range(0, 1));
        dmem_rdata = $urandom;
        exp_ld = (got && ld) ? ref_load(rd, off, rword) : last_load;
        #1;
        check("req_dropped", dmem_req, 0);
        check("stall_released", stall, 0);
        check("load_valid", load_valid, got && ld);
        check("bus_err", bus_err, !got);
        check("load_data", load_data, exp_ld);
        last_load = exp_ld;
        tick();
        clear_inputs();
        dmem_ack = 1'b0;
        #1;
        check("no_retrigger_req", dmem_req, 0);
        check("idle_stall", stall, 0);
        check("pulse_load_valid_cleared", load_valid, 0);
        check("pulse_bus_err_cleared", bus_err, 0);
        check("load_data_held", load_data, last_load);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        tick();
        tick();
        check("rst_dmem_req", dmem_req, 0);
        check("rst_dmem_we", dmem_we, 0);
        check("rst_dmem_addr", dmem_addr, 0);
        check("rst_dmem_wdata", dmem_wdata, 0);
        check("rst_dmem_be", dmem_be, 0);
        check("rst_stall", stall, 0);
        check("rst_load_data", load_data, 0);
        check("rst_load_valid", load_valid, 0);
        check("rst_misalign", misalign, 0);
        check("rst_bus_err", bus_err, 0);
        rst = 1'b0;
        tick();

        // Directed cases.
        run_op(3'd3, 2'd0, 32'h100, 32'h0, 32'hDEAD_BEEF, 0);
        check("lw_result", load_data, 32'hDEAD_BEEF);
        run_op(3'd1, 2'd0, 32'h103, 32'h0, 32'h80FF_FF7F, 0);
        check("lb_result", load_data, 32'hFFFF_FF80);
        run_op(3'd4, 2'd0, 32'h103, 32'h0, 32'h80FF_FF7F, 1);
        check("lbu_result", load_data, 32'h0000_0080);
        run_op(3'd5, 2'd0, 32'h102, 32'h0, 32'h80FF_FF7F, 2);
        check("lhu_result", load_data, 32'h0000_80FF);
        run_op(3'd0, 2'd2, 32'h206, 32'h1234_ABCD, 32'h0, 0);
        run_op(3'd3, 2'd0, 32'h101, 32'h0, 32'h0, 0);
        run_op(3'd3, 2'd0, 32'h400, 32'h0, 32'h1111_2222, 10);
        check("timeout_keeps_load", load_data, 32'h0000_80FF);
        run_op(3'd2, 2'd0, 32'h402, 32'h0, 32'h8001_0203, TMO - 1);
        check("ack_wins_at_limit", load_data, 32'hFFFF_8001);
        run_op(3'd3, 2'd1, 32'h501, 32'hA5A5_5A3C, 32'h0, 0);

        // Reset during the second REQ cycle, ack arriving just after.
        in_mem_read = 3'd3; in_mem_write = 2'd0; in_alu_result = 32'h300;
        tick();
        check("pre_rst_req", dmem_req, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_inputs();
        dmem_ack = 1'b1;
        dmem_rdata = 32'hCAFE_F00D;
        #1;
        check("rst_mid_req_dropped", dmem_req, 0);
        check("rst_mid_stall", stall, 0);
        check("rst_mid_load_data", load_data, 0);
        last_load = 32'h0;
        tick();
        dmem_ack = 1'b0;
        check("late_ack_no_load_valid", load_valid, 0);
        check("late_ack_no_req", dmem_req, 0);
        tick();

        // Random traffic.
        for (int i = 0; i < 80; i++) begin
            logic [2:0]  r_rd;
            logic [1:0]  r_wr;
            r_rd = 3'($urandom_range(0, 7));
            r_wr = ($urandom_range(0, 9) < 3) ? 2'($urandom_range(1, 3)) : 2'd0;
            run_op(r_rd, r_wr, $urandom, $urandom, $urandom, $urandom_range(0, TMO + 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
